// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_stage.sv
// if_stage: PC, single-outstanding imem fetch, IF/ID register with stall skid buffer
// and redirect flush.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    fetch_state_e r_state, w_next;
    logic [31:0]  r_pc, r_req_pc, w_target;
    logic         r_kill;
    if_id_t       r_ifid, r_skid, w_word;
    logic         w_accept, w_rsp, w_live_rsp, w_to_ifid, w_park;

    assign w_target   = redirect_pc & ~32'd3;
    assign w_accept   = (r_state == FETCH) && imem_req_ready;
    assign w_rsp      = (r_state == WAIT) && imem_rsp_valid;
    assign w_live_rsp = w_rsp && !r_kill && !redirect_valid;
    assign w_to_ifid  = !stall && (w_live_rsp || (r_state == HOLD));
    assign w_park     = w_live_rsp && stall;
    assign w_word     = (r_state == HOLD) ? r_skid : {1'b1, r_req_pc, imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT:    w_next = FETCH;
            FETCH:   w_next = imem_req_ready ? WAIT : FETCH;
            WAIT:    w_next = !imem_rsp_valid ? WAIT :
                              (r_kill || redirect_valid || !stall) ? FETCH : HOLD;
            HOLD:    w_next = (redirect_valid || !stall) ? FETCH : HOLD;
            default: w_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == FETCH);
        imem_addr      = r_pc;
        ifid_valid     = r_ifid.valid;
        ifid_pc        = r_ifid.pc;
        ifid_instr     = r_ifid.instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
            r_ifid   <= {1'b0, 32'h0, NOP_INSTR};
            r_skid   <= {1'b0, 32'h0, NOP_INSTR};
        end else begin
            if (redirect_valid) begin
                r_pc <= w_target;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            // an in-flight request that a redirect overtakes must be discarded on return
            if (w_rsp) begin
                r_kill <= 1'b0;
            end else if (redirect_valid && ((r_state == WAIT) || w_accept)) begin
                r_kill <= 1'b1;
            end
            if (redirect_valid) begin
                r_ifid <= {1'b0, r_ifid.pc, NOP_INSTR};
            end else if (w_to_ifid) begin
                r_ifid <= w_word;
            end else if (!stall) begin
                r_ifid <= {1'b0, r_ifid.pc, NOP_INSTR};
            end
            if (w_park) begin
                r_skid <= {1'b1, r_req_pc, imem_rsp_data};
            end
        end
    end

endmodule
